// File: rtl/pipe_hazard_ctrl.sv
// Hazard/forwarding controller: in-flight destination scoreboard, EX forwarding selects,
// load-use, conditional-branch, memory-busy and halt stalls. Optional HAZ_STATS_EN adds stall counters.
module pipe_hazard_ctrl #(
  parameter int NREG           = 16,
  parameter int DEPTH          = 3,
  parameter int LOAD_FWD_STAGE = 2,
  parameter int BR_STALL       = 1,
  localparam int REG_W         = $clog2(NREG),
  localparam int FS_W          = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_rs_used,
  input  logic             id_rt_used,
  input  logic             id_regwrite,
  input  logic [REG_W-1:0] id_dst,
  input  logic             id_load,
  input  logic             id_cond_br,
  input  logic             id_halt,
  input  logic             id_flush,
  input  logic             mem_busy,
  output logic             stall,
  output logic             bubble,
  output logic [FS_W-1:0]  fwd_a,
  output logic [FS_W-1:0]  fwd_b,
  output logic             hlt
`ifdef HAZ_STATS_EN
  ,
  output logic [15:0]      stall_cyc,
  output logic [15:0]      lu_cyc
`endif
);

  localparam int CNT_W = (BR_STALL < 1) ? 1 : $clog2(BR_STALL + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((BR_STALL > 0) ? BR_STALL - 1 : 0);

  typedef enum logic [1:0] {IDLE, WAIT, GO} br_state_t;

  typedef struct packed {
    logic             v;
    logic             wr;
    logic [REG_W-1:0] dst;
    logic             ld;
    logic             hl;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic             rs_u;
    logic             rt_u;
  } entry_t;

  entry_t           sb [DEPTH];
  entry_t           sb_in;
  br_state_t        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             halt_pend, hlt_q;
  logic             lu_hit, lu, br_start, fsm_stall, issue;

  function automatic logic match(input entry_t e, input logic [REG_W-1:0] r);
    return e.v && e.wr && (e.dst == r) && (r != '0);
  endfunction

  // A load at stage k is not forwardable to the ID instruction until it reaches LOAD_FWD_STAGE-1
  always_comb begin
    lu_hit = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (sb[k].ld && (k + 1 < LOAD_FWD_STAGE) &&
          ((id_rs_used && match(sb[k], id_rs)) || (id_rt_used && match(sb[k], id_rt))))
        lu_hit = 1'b1;
    end
  end

  assign lu        = id_valid && !id_flush && lu_hit;
  assign br_start  = (BR_STALL > 0) && (state == IDLE) && id_valid && id_cond_br &&
                     !id_flush && !lu && !mem_busy && !halt_pend;
  assign fsm_stall = br_start || (state == WAIT);
  // Gated by rst_n so an asserted reset leaves no residual stall from ID inputs
  assign stall     = rst_n && (mem_busy || halt_pend || lu || fsm_stall);
  assign bubble    = rst_n && !mem_busy && (lu || fsm_stall || halt_pend);
  assign issue     = id_valid && !id_flush && !stall && !mem_busy;
  assign hlt       = hlt_q || (sb[DEPTH-1].v && sb[DEPTH-1].hl);

  // Descending scan so the youngest producer wins
  always_comb begin
    fwd_a = '0;
    fwd_b = '0;
    for (int k = DEPTH - 1; k >= 1; k--) begin
      if (!(sb[k].ld && (k < LOAD_FWD_STAGE))) begin
        if (sb[0].rs_u && match(sb[k], sb[0].rs)) fwd_a = FS_W'(k);
        if (sb[0].rt_u && match(sb[k], sb[0].rt)) fwd_b = FS_W'(k);
      end
    end
  end

  // The IDLE detection cycle is the first stall cycle; WAIT covers the remaining BR_STALL-1
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (!mem_busy) begin
      case (state)
        IDLE: if (br_start) begin
          cnt_nxt   = CNT_LOAD;
          state_nxt = (CNT_LOAD == '0) ? GO : WAIT;
        end
        WAIT: if (id_flush) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt - 1'b1;
          if (cnt <= CNT_W'(1)) state_nxt = GO;
        end
        GO:   if (issue || id_flush) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    sb_in = '0;
    if (issue) begin
      sb_in.v    = 1'b1;
      sb_in.wr   = id_regwrite;
      sb_in.dst  = id_dst;
      sb_in.ld   = id_load;
      sb_in.hl   = id_halt;
      sb_in.rs   = id_rs;
      sb_in.rt   = id_rt;
      sb_in.rs_u = id_rs_used;
      sb_in.rt_u = id_rt_used;
    end
  end

  // Scoreboard shift: stage boundary ID -> EX -> ... -> DEPTH-1, frozen while memory is busy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) sb[k] <= '0;
    end else if (!mem_busy) begin
      sb[0] <= sb_in;
      for (int k = 1; k < DEPTH; k++) sb[k] <= sb[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halt_pend <= 1'b0;
      hlt_q     <= 1'b0;
    end else begin
      if (issue && id_halt) halt_pend <= 1'b1;
      if (sb[DEPTH-1].v && sb[DEPTH-1].hl) hlt_q <= 1'b1;
    end
  end

`ifdef HAZ_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cyc <= '0;
      lu_cyc    <= '0;
    end else begin
      if (stall && (stall_cyc != '1)) stall_cyc <= stall_cyc + 16'd1;
      if (lu && (lu_cyc != '1))       lu_cyc    <= lu_cyc + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl at default parameters; expected outputs are queued
// as each ID cycle is driven and popped when the outputs settle.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid, id_rs_used, id_rt_used, id_regwrite, id_load;
  logic       id_cond_br, id_halt, id_flush, mem_busy;
  logic [3:0] id_rs, id_rt, id_dst;
  logic       stall, bubble, hlt;
  logic [1:0] fwd_a, fwd_b;
`ifdef HAZ_STATS_EN
  logic [15:0] stall_cyc, lu_cyc;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic       v, rsu, rtu, wr, ld, cb, hl, fl, mb;
    logic [3:0] rs, rt, dst;
  } drv_t;

  typedef struct packed {
    logic       st, bu;
    logic [1:0] fa, fb;
    logic       hl;
  } exp_t;

  exp_t exp_q[$];

  pipe_hazard_ctrl dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_regwrite(id_regwrite),
    .id_dst(id_dst), .id_load(id_load), .id_cond_br(id_cond_br), .id_halt(id_halt),
    .id_flush(id_flush), .mem_busy(mem_busy), .stall(stall), .bubble(bubble),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .hlt(hlt)
`ifdef HAZ_STATS_EN
    , .stall_cyc(stall_cyc), .lu_cyc(lu_cyc)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic drv_t nop();
    drv_t d;
    d = '0;
    return d;
  endfunction

  function automatic drv_t alu(input logic [3:0] dst, input logic [3:0] rs, input logic [3:0] rt);
    drv_t d;
    d = '0;
    d.v = 1'b1; d.wr = 1'b1; d.dst = dst;
    d.rs = rs; d.rt = rt; d.rsu = 1'b1; d.rtu = 1'b1;
    return d;
  endfunction

  function automatic drv_t lw(input logic [3:0] dst, input logic [3:0] rs);
    drv_t d;
    d = '0;
    d.v = 1'b1; d.wr = 1'b1; d.ld = 1'b1; d.dst = dst; d.rs = rs; d.rsu = 1'b1;
    return d;
  endfunction

  function automatic drv_t br(input logic [3:0] rs);
    drv_t d;
    d = '0;
    d.v = 1'b1; d.cb = 1'b1; d.rs = rs; d.rsu = 1'b1;
    return d;
  endfunction

  function automatic drv_t halt();
    drv_t d;
    d = '0;
    d.v = 1'b1; d.hl = 1'b1;
    return d;
  endfunction

  function automatic exp_t ex(input logic st, input logic bu, input logic [1:0] fa,
                              input logic [1:0] fb, input logic hl);
    exp_t e;
    e.st = st; e.bu = bu; e.fa = fa; e.fb = fb; e.hl = hl;
    return e;
  endfunction

  task automatic apply(input drv_t d);
    id_valid = d.v;  id_rs = d.rs; id_rt = d.rt; id_rs_used = d.rsu; id_rt_used = d.rtu;
    id_regwrite = d.wr; id_dst = d.dst; id_load = d.ld; id_cond_br = d.cb;
    id_halt = d.hl; id_flush = d.fl; mem_busy = d.mb;
  endtask

  task automatic compare(input string tag);
    exp_t e;
    e = exp_q.pop_front();
    chk({tag, ".stall"},  32'(stall),  32'(e.st));
    chk({tag, ".bubble"}, 32'(bubble), 32'(e.bu));
    chk({tag, ".fwd_a"},  32'(fwd_a),  32'(e.fa));
    chk({tag, ".fwd_b"},  32'(fwd_b),  32'(e.fb));
    chk({tag, ".hlt"},    32'(hlt),    32'(e.hl));
  endtask

  task automatic step(input drv_t d, input exp_t e, input string tag);
    @(negedge clk);
    apply(d);
    exp_q.push_back(e);
    #2;
    compare(tag);
  endtask

  // Asynchronous reset asserted mid-cycle with the current ID inputs still applied
  task automatic pulse_rst(input string tag);
    #1 rst_n = 1'b0;
    exp_q.push_back(ex(0, 0, 0, 0, 0));
    #1;
    compare(tag);
    @(negedge clk);
    apply(nop());
    rst_n = 1'b1;
  endtask

  initial begin
    drv_t d;
    rst_n = 1'b0;
    apply(nop());
    repeat (2) @(posedge clk);
    #1;
    exp_q.push_back(ex(0, 0, 0, 0, 0));
    compare("reset");
`ifdef HAZ_STATS_EN
    chk("stats_reset", 32'({stall_cyc, lu_cyc}), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Forwarding distances, R0 exclusion, youngest-producer priority
    step(alu(3, 1, 2),  ex(0, 0, 0, 0, 0), "add_r3");
    step(alu(4, 3, 1),  ex(0, 0, 0, 0, 0), "sub_r3");
    step(nop(),         ex(0, 0, 1, 0, 0), "fwd_dist1");
    step(alu(7, 1, 1),  ex(0, 0, 0, 0, 0), "add_r7");
    step(alu(8, 2, 2),  ex(0, 0, 0, 0, 0), "unrel_r8");
    step(alu(9, 2, 7),  ex(0, 0, 0, 0, 0), "rd_r7");
    step(nop(),         ex(0, 0, 0, 2, 0), "fwd_b_dist2");
    step(alu(0, 1, 1),  ex(0, 0, 0, 0, 0), "wr_r0");
    step(alu(10, 0, 0), ex(0, 0, 0, 0, 0), "rd_r0");
    step(nop(),         ex(0, 0, 0, 0, 0), "r0_nomatch");
    step(alu(5, 1, 1),  ex(0, 0, 0, 0, 0), "r5_old");
    step(alu(5, 2, 2),  ex(0, 0, 0, 0, 0), "r5_new");
    step(alu(11, 5, 5), ex(0, 0, 0, 0, 0), "rd_r5");
    step(nop(),         ex(0, 0, 1, 1, 0), "fwd_youngest");
    step(alu(3, 1, 2),  ex(0, 0, 0, 0, 0), "add_r3b");
    step(alu(12, 1, 1), ex(0, 0, 0, 0, 0), "unrel_r12");
    step(alu(13, 3, 1), ex(0, 0, 0, 0, 0), "rd_r3b");
    step(nop(),         ex(0, 0, 2, 0, 0), "fwd_a_dist2");

    // Load-use: one stall cycle, then forwarding from stage 2
    step(lw(5, 1),      ex(0, 0, 0, 0, 0), "lw_r5");
    step(alu(6, 5, 2),  ex(1, 1, 0, 0, 0), "lu_stall");
    step(alu(6, 5, 2),  ex(0, 0, 0, 0, 0), "lu_issue");
    step(nop(),         ex(0, 0, 2, 0, 0), "lu_fwd2");
`ifdef HAZ_STATS_EN
    chk("lu_cyc_1", 32'(lu_cyc), 32'd1);
    chk("stall_cyc_1", 32'(stall_cyc), 32'd1);
`endif

    // Load-use with a 3-cycle memory freeze in the middle
    step(lw(5, 1),      ex(0, 0, 0, 0, 0), "lw_r5b");
    d = alu(6, 5, 5);
    d.mb = 1'b1;
    step(d,             ex(1, 0, 0, 0, 0), "busy1");
    step(d,             ex(1, 0, 0, 0, 0), "busy2");
    step(d,             ex(1, 0, 0, 0, 0), "busy3");
    step(alu(6, 5, 5),  ex(1, 1, 0, 0, 0), "lu_resume");
    step(alu(6, 5, 5),  ex(0, 0, 0, 0, 0), "lu_issue_b");
    step(nop(),         ex(0, 0, 2, 2, 0), "lu_fwd2_b");
`ifdef HAZ_STATS_EN
    chk("lu_cyc_5", 32'(lu_cyc), 32'd5);
    chk("stall_cyc_5", 32'(stall_cyc), 32'd5);
`endif

    // Conditional branch: single stall cycle; flush in GO squashes and returns to IDLE
    step(br(1),         ex(1, 1, 0, 0, 0), "br_stall");
    step(br(1),         ex(0, 0, 0, 0, 0), "br_issue");
    step(br(2),         ex(1, 1, 0, 0, 0), "br2_stall");
    d = br(2);
    d.fl = 1'b1; d.wr = 1'b1; d.dst = 4'd14;
    step(d,             ex(0, 0, 0, 0, 0), "br2_flush");
    step(alu(15, 14, 14), ex(0, 0, 0, 0, 0), "after_flush");
    step(br(1),         ex(1, 1, 0, 0, 0), "br3_stall_noissue");
    step(br(1),         ex(0, 0, 0, 0, 0), "br3_issue");

    // Halt drain
    step(halt(),        ex(0, 0, 0, 0, 0), "hlt_issue");
    step(alu(1, 2, 3),  ex(1, 1, 0, 0, 0), "hlt_pend1");
    step(alu(1, 2, 3),  ex(1, 1, 0, 0, 0), "hlt_pend2");
    step(alu(1, 2, 3),  ex(1, 1, 0, 0, 1), "hlt_rise");
    step(alu(1, 2, 3),  ex(1, 1, 0, 0, 1), "hlt_sticky");
    pulse_rst("rst_in_halt");

    // Reset while a branch stall is active with valid entries
    step(alu(3, 1, 2),  ex(0, 0, 0, 0, 0), "rst_add_r3");
    step(alu(4, 3, 3),  ex(0, 0, 0, 0, 0), "rst_add_r4");
    step(br(4),         ex(1, 1, 1, 1, 0), "rst_br_stall");
    pulse_rst("rst_in_br");
`ifdef HAZ_STATS_EN
    chk("stats_cleared", 32'({stall_cyc, lu_cyc}), 32'd0);
`endif
    step(alu(5, 4, 4),  ex(0, 0, 0, 0, 0), "post_rst_issue");
    step(nop(),         ex(0, 0, 0, 0, 0), "post_rst_clean");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
